// File: rtl/register_file_arbiter.sv
// register_file_arbiter
// Shares the single register-number/data port of the register bank between
// the instruction decoder (writes) and the print module (reads). Requests are
// level-held until acknowledged. The decoder normally wins, but a waiting
// print request is served after MAX_DEC_BURST consecutive decoder grants.
// Every output comes straight from a flop.
module register_file_arbiter #(
  parameter int DATA_W        = 32,
  parameter int NUM_REGS      = 32,
  parameter int READ_LAT      = 1,
  parameter int MAX_DEC_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_req,
  input  logic [4:0]        dec_reg,
  input  logic [DATA_W-1:0] dec_data,
  output logic              dec_ack,
  input  logic              prt_req,
  input  logic [4:0]        prt_reg,
  output logic [DATA_W-1:0] prt_data,
  output logic              prt_valid,
  output logic              mux_sel,
  output logic [4:0]        rf_reg,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_we,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy
);

  localparam int                 BURST_W   = $clog2(MAX_DEC_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DEC_BURST);
  localparam logic [1:0]         WAIT_INIT = 2'(READ_LAT - 1);
  // One bit per register number; a clear bit marks a number with no register behind it.
  localparam logic [31:0]        REG_VALID = (NUM_REGS >= 32) ? 32'hFFFF_FFFF
                                           : ((32'd1 << NUM_REGS) - 32'd1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [1:0]          r_wait, w_wait_nxt;
  logic [BURST_W-1:0]  r_burst, w_burst_nxt;
  logic                r_dec_ack, w_dec_ack_nxt;
  logic                r_prt_valid, w_prt_valid_nxt;
  logic [DATA_W-1:0]   r_prt_data, w_prt_data_nxt;
  logic                r_mux_sel, w_mux_sel_nxt;
  logic [4:0]          r_rf_reg, w_rf_reg_nxt;
  logic [DATA_W-1:0]   r_rf_wdata, w_rf_wdata_nxt;
  logic                r_rf_we, w_rf_we_nxt;
  logic                r_busy;

  logic                w_burst_full;
  logic                w_prt_win;

  assign w_burst_full = (r_burst == BURST_MAX);
  // Print wins if the decoder is silent or has already used its burst allowance.
  assign w_prt_win    = prt_req && (!dec_req || w_burst_full);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    w_state_nxt     = r_state;
    w_wait_nxt      = r_wait;
    w_burst_nxt     = r_burst;
    w_dec_ack_nxt   = 1'b0;
    w_prt_valid_nxt = 1'b0;
    w_prt_data_nxt  = r_prt_data;
    w_mux_sel_nxt   = r_mux_sel;
    w_rf_reg_nxt    = r_rf_reg;
    w_rf_wdata_nxt  = r_rf_wdata;
    w_rf_we_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_prt_win) begin
          w_rf_reg_nxt  = prt_reg;
          w_mux_sel_nxt = 1'b1;
          w_burst_nxt   = '0;
          w_wait_nxt    = WAIT_INIT;
          w_state_nxt   = READ;
        end else if (dec_req) begin
          w_rf_reg_nxt   = dec_reg;
          w_rf_wdata_nxt = dec_data;
          w_mux_sel_nxt  = 1'b0;
          // Write strobe and ack are both visible during the single WRITE cycle.
          w_rf_we_nxt    = REG_VALID[dec_reg];
          w_dec_ack_nxt  = 1'b1;
          w_state_nxt    = WRITE;
          if (!prt_req)          w_burst_nxt = '0;
          else if (!w_burst_full) w_burst_nxt = r_burst + 1'b1;
        end else begin
          // Reaching here means prt_req is low, so nobody is being starved.
          w_burst_nxt = '0;
        end
      end
      WRITE: begin
        w_state_nxt = IDLE;
      end
      READ: begin
        if (r_wait == 2'd0) begin
          // Bank data has had READ_LAT cycles to settle on this edge.
          w_prt_data_nxt  = REG_VALID[r_rf_reg] ? rf_rdata : '0;
          w_prt_valid_nxt = 1'b1;
          w_state_nxt     = DONE;
        end else begin
          w_wait_nxt = r_wait - 2'd1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Control counters and handshake/output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait      <= '0;
      r_burst     <= '0;
      r_dec_ack   <= 1'b0;
      r_prt_valid <= 1'b0;
      r_prt_data  <= '0;
      r_mux_sel   <= 1'b0;
      r_rf_reg    <= '0;
      r_rf_wdata  <= '0;
      r_rf_we     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_wait      <= w_wait_nxt;
      r_burst     <= w_burst_nxt;
      r_dec_ack   <= w_dec_ack_nxt;
      r_prt_valid <= w_prt_valid_nxt;
      r_prt_data  <= w_prt_data_nxt;
      r_mux_sel   <= w_mux_sel_nxt;
      r_rf_reg    <= w_rf_reg_nxt;
      r_rf_wdata  <= w_rf_wdata_nxt;
      r_rf_we     <= w_rf_we_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign dec_ack   = r_dec_ack;
  assign prt_valid = r_prt_valid;
  assign prt_data  = r_prt_data;
  assign mux_sel   = r_mux_sel;
  assign rf_reg    = r_rf_reg;
  assign rf_wdata  = r_rf_wdata;
  assign rf_we     = r_rf_we;
  assign busy      = r_busy;

endmodule

// File: tb/tb_register_file_arbiter.sv
// Bench for register_file_arbiter: three instances (32 regs/lat 1,
// 16 regs/lat 2, 16 regs/lat 3), each with its own latency-modelled bank.
// A transaction-level memory model predicts write effects and read data.
module tb_register_file_arbiter;
  localparam int NI   = 3;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NI-1:0]         dec_req, prt_req, dec_ack, prt_valid, mux_sel, rf_we, busy;
  logic [NI-1:0][4:0]    dec_reg, prt_reg, rf_reg;
  logic [NI-1:0][DW-1:0] dec_data, prt_data, rf_wdata, rf_rdata;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_mem [NI][32];
  logic [DW-1:0] exp_pdata [NI];

  function automatic int cfg_lat(input int k); return k + 1; endfunction
  function automatic int cfg_nr(input int k); return (k == 0) ? 32 : 16; endfunction
  function automatic logic [DW-1:0] init_val(input int k, input int i);
    return 32'hA500_0000 | 32'(k << 16) | 32'(i);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int LAT = g + 1;
    localparam int NR  = (g == 0) ? 32 : 16;
    logic [DW-1:0] mem [32];
    logic [4:0]    apd [1:3];

    register_file_arbiter #(.DATA_W(DW), .NUM_REGS(NR), .READ_LAT(LAT), .MAX_DEC_BURST(MAXB)) dut (
      .clk(clk), .reset(reset),
      .dec_req(dec_req[g]), .dec_reg(dec_reg[g]), .dec_data(dec_data[g]), .dec_ack(dec_ack[g]),
      .prt_req(prt_req[g]), .prt_reg(prt_reg[g]), .prt_data(prt_data[g]), .prt_valid(prt_valid[g]),
      .mux_sel(mux_sel[g]), .rf_reg(rf_reg[g]), .rf_wdata(rf_wdata[g]), .rf_we(rf_we[g]),
      .rf_rdata(rf_rdata[g]), .busy(busy[g]));

    initial for (int i = 0; i < 32; i++) mem[i] <= init_val(g, i);

    // Bank: synchronous write, read data delayed LAT-1 cycles behind the address.
    always @(posedge clk) begin
      if (rf_we[g]) mem[rf_reg[g]] <= rf_wdata[g];
      apd[1] <= rf_reg[g];
      apd[2] <= apd[1];
      apd[3] <= apd[2];
    end
    if (LAT == 1) begin : g_l1
      assign rf_rdata[g] = mem[rf_reg[g]];
    end else begin : g_ln
      assign rf_rdata[g] = mem[apd[LAT-1]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input int k, input string tag);
    chk({tag, "_busy"},    64'(busy[k]),      64'd0);
    chk({tag, "_ack"},     64'(dec_ack[k]),   64'd0);
    chk({tag, "_valid"},   64'(prt_valid[k]), 64'd0);
    chk({tag, "_we"},      64'(rf_we[k]),     64'd0);
    chk({tag, "_mux"},     64'(mux_sel[k]),   64'd0);
    chk({tag, "_rfreg"},   64'(rf_reg[k]),    64'd0);
    chk({tag, "_wdata"},   64'(rf_wdata[k]),  64'd0);
    chk({tag, "_prtdata"}, 64'(prt_data[k]),  64'd0);
  endtask

  // Issue a write, a read, or both at once from an idle arbiter and check the outcome.
  task automatic run_pair(input int k, input bit dw, input logic [4:0] wr, input logic [31:0] wd,
                          input bit dr, input logic [4:0] rr);
    bit wdone, rdone;
    int t, ack_t, val_t, exp_val_t;
    wdone = !dw; rdone = !dr; t = 0; ack_t = -1; val_t = -1;
    exp_val_t = dr ? (dw ? 3 + cfg_lat(k) : 1 + cfg_lat(k)) : -1;
    dec_req[k] = dw; dec_reg[k] = wr; dec_data[k] = wd;
    prt_req[k] = dr; prt_reg[k] = rr;
    while (!(wdone && rdone) && t < 20) begin
      @(negedge clk); t++;
      if (dec_ack[k]) begin
        ack_t = t;
        chk("wr_rf_we",  64'(rf_we[k]),    64'(int'(wr) < cfg_nr(k)));
        chk("wr_rf_reg", 64'(rf_reg[k]),   64'(wr));
        chk("wr_wdata",  64'(rf_wdata[k]), 64'(wd));
        chk("wr_mux",    64'(mux_sel[k]),  64'd0);
        chk("wr_busy",   64'(busy[k]),     64'd1);
        if (int'(wr) < cfg_nr(k)) exp_mem[k][wr] = wd;
        dec_req[k] = 1'b0; wdone = 1'b1;
      end else if (busy[k]) begin
        chk("rd_mux",   64'(mux_sel[k]), 64'd1);
        chk("rd_no_we", 64'(rf_we[k]),   64'd0);
      end
      if (prt_valid[k]) begin
        val_t = t;
        exp_pdata[k] = (int'(rr) < cfg_nr(k)) ? exp_mem[k][rr] : '0;
        chk("rd_data", 64'(prt_data[k]), 64'(exp_pdata[k]));
        prt_req[k] = 1'b0; rdone = 1'b1;
      end
    end
    dec_req[k] = 1'b0; prt_req[k] = 1'b0;
    chk("ack_time",   64'(ack_t), dw ? 64'd1 : 64'(-1));
    chk("valid_time", 64'(val_t), 64'(exp_val_t));
    @(negedge clk);
    chk("ack_pulse",   64'(dec_ack[k]),   64'd0);
    chk("valid_pulse", 64'(prt_valid[k]), 64'd0);
    chk("idle_busy",   64'(busy[k]),      64'd0);
    chk("data_hold",   64'(prt_data[k]),  64'(exp_pdata[k]));
  endtask

  // Decoder hammers writes while a read waits: MAXB writes, the read, then writes resume.
  task automatic run_starve(input int k, input logic [4:0] rr);
    int nb, na, t;
    bit got;
    logic [4:0]  r;
    logic [31:0] d;
    nb = 0; na = 0; t = 0; got = 1'b0; r = 5'd1; d = $urandom;
    dec_req[k] = 1'b1; dec_reg[k] = r; dec_data[k] = d;
    prt_req[k] = 1'b1; prt_reg[k] = rr;
    while (na < 2 && t < 100) begin
      @(negedge clk); t++;
      if (dec_ack[k]) begin
        exp_mem[k][r] = d;
        if (got) na++; else nb++;
        r = r + 5'd1; d = $urandom;
        dec_reg[k] = r; dec_data[k] = d;
        if (na == 2) dec_req[k] = 1'b0;
      end
      if (prt_valid[k]) begin
        exp_pdata[k] = exp_mem[k][rr];
        chk("starve_data", 64'(prt_data[k]), 64'(exp_pdata[k]));
        got = 1'b1; prt_req[k] = 1'b0;
      end
    end
    dec_req[k] = 1'b0; prt_req[k] = 1'b0;
    chk("starve_writes_before", 64'(nb), 64'(MAXB));
    chk("starve_read_done",     64'(got), 64'd1);
    chk("starve_writes_after",  64'(na), 64'd2);
    @(negedge clk);
    chk("starve_idle", 64'(busy[k]), 64'd0);
  endtask

  // Continuous properties: strobe only with ack, mux/reg frozen within a transaction,
  // no handshakes while reset is held.
  logic [NI-1:0]      p_busy, p_mux;
  logic [NI-1:0][4:0] p_reg;
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        chk("rst_no_ack",   64'(dec_ack[k]),   64'd0);
        chk("rst_no_valid", 64'(prt_valid[k]), 64'd0);
        chk("rst_no_we",    64'(rf_we[k]),     64'd0);
      end else begin
        if (rf_we[k]) chk("we_with_ack", 64'(dec_ack[k]), 64'd1);
        if (busy[k] && p_busy[k]) begin
          chk("hold_rf_reg", 64'(rf_reg[k]),  64'(p_reg[k]));
          chk("hold_mux",    64'(mux_sel[k]), 64'(p_mux[k]));
        end
      end
    end
    p_busy <= busy; p_mux <= mux_sel; p_reg <= rf_reg;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bit got;
    reset = 1'b1;
    dec_req = '0; prt_req = '0; dec_reg = '0; dec_data = '0; prt_reg = '0;
    for (int k = 0; k < NI; k++) begin
      exp_pdata[k] = '0;
      for (int i = 0; i < 32; i++) exp_mem[k][i] = init_val(k, i);
    end
    #3;
    for (int k = 0; k < NI; k++) chk_reset_vals(k, "por");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Simultaneous first request: write wins, read follows in the next IDLE.
    run_pair(0, 1'b1, 5'd3, 32'hCAFE_0003, 1'b1, 5'd3);
    run_pair(1, 1'b1, 5'd4, 32'hCAFE_0104, 1'b1, 5'd4);
    // Single write and single reads at latency 1 and 2.
    run_pair(0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
    run_pair(0, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0);
    run_pair(0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd7);
    run_pair(1, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0);
    run_pair(1, 1'b0, 5'd0, 32'h0,         1'b1, 5'd7);
    // Out of range on a 16-register bank.
    run_pair(1, 1'b1, 5'd20, 32'hBAD0_0020, 1'b0, 5'd0);
    run_pair(1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd20);
    run_pair(1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7);
    // Starvation bound.
    run_starve(0, 5'd3);

    // Randomized traffic against the memory model.
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 25; n++) begin
        int sel;
        sel = int'($urandom_range(0, 2));
        run_pair(k, sel != 1, 5'($urandom_range(0, 31)), $urandom,
                    sel != 0, 5'($urandom_range(0, 31)));
      end
    end

    // Reset in READ on the latency-3 instance, then the held read restarts.
    run_pair(2, 1'b1, 5'd9, 32'h0909_0909, 1'b0, 5'd0);
    run_pair(2, 1'b0, 5'd0, 32'h0,         1'b1, 5'd9);
    prt_req[2] = 1'b1; prt_reg[2] = 5'd9;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_busy", 64'(busy[2]),    64'd1);
    chk("pre_rst_mux",  64'(mux_sel[2]), 64'd1);
    #2 reset = 1'b1;
    #1 chk_reset_vals(2, "midrst");
    for (int k = 0; k < NI; k++) exp_pdata[k] = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    t = 0; got = 1'b0;
    while (!got && t < 20) begin
      @(negedge clk); t++;
      if (prt_valid[2]) begin
        got = 1'b1;
        exp_pdata[2] = exp_mem[2][9];
        chk("rst_rd_data", 64'(prt_data[2]), 64'(exp_pdata[2]));
        prt_req[2] = 1'b0;
      end
    end
    prt_req[2] = 1'b0;
    chk("rst_rd_time", 64'(t), 64'(cfg_lat(2) + 1));
    @(negedge clk);
    chk("rst_rd_idle", 64'(busy[2]), 64'd0);
    run_pair(2, 1'b1, 5'd2, 32'h0202_0202, 1'b1, 5'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
